mips_multicycle_ctrl: RTL

Multi-cycle main control FSM for the MIPS datapath. It decodes the instruction opcode, sequences fetch/decode/execute/memory/writeback, and drives every datapath strobe and mux select. It produces the 3-bit ALUOp consumed by the ALU control decoder. It also handles the variable-latency memory handshake, and traps on illegal opcodes or memory timeout.

---
 rtl/mips_multicycle_ctrl.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle main control FSM for a MIPS datapath: instruction sequencing,
// datapath strobes and mux selects, ALUOp generation, variable-latency memory
// handshake with timeout, and a sticky trap on illegal opcode or timeout.
module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       regs_eq,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtZero,
    output logic [2:0] ALUOp,
    output logic [1:0] PCSrc,
    output logic       trap,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_R_EXEC    = 4'd7,
        S_R_WB      = 4'd8,
        S_I_EXEC    = 4'd9,
        S_I_WB      = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_TRAP      = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_ADDIU = 6'd9;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    // Count value after which one more idle memory cycle means timeout
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    logic [5:0]       op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;

    // ALU operation for the immediate-arithmetic group
    function automatic logic [2:0] imm_aluop(input logic [5:0] op);
        case (op)
            OP_ADDI:  return 3'd6;
            OP_ADDIU: return 3'd7;
            OP_SLTI:  return 3'd3;
            OP_ANDI:  return 3'd4;
            OP_ORI:   return 3'd5;
            default:  return 3'd2;
        endcase
    endfunction

    // Logical immediates are zero-extended, everything else sign-extended
    function automatic logic imm_zext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

    // Timeout fires when this stalled cycle would bring the count to the limit;
    // a mem_ready on that same cycle takes precedence
    always_comb begin
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST) && !mem_ready;
    end

    // State register, latched opcode and memory wait counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= '0;
            case (state_q)
                S_IDLE: state_q <= S_FETCH;
                S_FETCH: begin
                    if (mem_ready)        state_q <= S_DECODE;
                    else if (timeout_hit) state_q <= S_TRAP;
                    else                  cnt_q   <= cnt_q + 1'b1;
                end
                S_DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_LW, OP_SW:                 state_q <= S_MEM_ADDR;
                        OP_RTYPE:                     state_q <= S_R_EXEC;
                        OP_ADDI, OP_ADDIU, OP_SLTI,
                        OP_ANDI, OP_ORI:              state_q <= S_I_EXEC;
                        OP_BEQ, OP_BNE:               state_q <= S_BRANCH;
                        OP_J:                         state_q <= S_JUMP;
                        default:                      state_q <= S_TRAP;
                    endcase
                end
                S_MEM_ADDR: state_q <= (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ: begin
                    if (mem_ready)        state_q <= S_MEM_WB;
                    else if (timeout_hit) state_q <= S_TRAP;
                    else                  cnt_q   <= cnt_q + 1'b1;
                end
                S_MEM_WB: state_q <= S_FETCH;
                S_MEM_WRITE: begin
                    if (mem_ready)        state_q <= S_FETCH;
                    else if (timeout_hit) state_q <= S_TRAP;
                    else                  cnt_q   <= cnt_q + 1'b1;
                end
                S_R_EXEC: state_q <= S_R_WB;
                S_R_WB:   state_q <= S_FETCH;
                S_I_EXEC: state_q <= S_I_WB;
                S_I_WB:   state_q <= S_FETCH;
                S_BRANCH: state_q <= S_FETCH;
                S_JUMP:   state_q <= S_FETCH;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_TRAP;
            endcase
        end
    end

    // Datapath controls decoded from state and latched opcode
    always_comb begin
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'd0;
        ExtZero  = 1'b0;
        ALUOp    = 3'd2;
        PCSrc    = 2'd0;
        trap     = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'd1;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: ALUSrcB = 2'd3;
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'd1;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'd2;
                ALUOp   = imm_aluop(op_q);
                ExtZero = imm_zext(op_q);
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                ALUOp    = imm_aluop(op_q);
                ExtZero  = imm_zext(op_q);
            end
            S_BRANCH: begin
                PCSrc   = 2'd1;
                PCWrite = (op_q == OP_BEQ) ? regs_eq : !regs_eq;
            end
            S_JUMP: begin
                PCSrc   = 2'd2;
                PCWrite = 1'b1;
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule
